// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the keypad scanner: FSM states, column strobe
// patterns (shared with the seven-segment display driver) and key helpers.
package keypad_scanner_pkg;

  typedef enum logic [1:0] {
    StScan,
    StDebounce,
    StHold
  } scan_state_e;

  // Active-low one-hot-zero strobes, identical to the display anode pattern.
  localparam logic [3:0] ColStrobe0 = 4'b1110;
  localparam logic [3:0] ColStrobe1 = 4'b1101;
  localparam logic [3:0] ColStrobe2 = 4'b1011;
  localparam logic [3:0] ColStrobe3 = 4'b0111;

  // Rows read all-high when no key in the driven column is pressed.
  localparam logic [3:0] RowsIdle = 4'hF;

  // Key at row 3, column 3; optionally acts as a clear key.
  localparam logic [3:0] ClrKeyCode = 4'hF;

  function automatic logic [3:0] col_strobe(input logic [1:0] idx);
    logic [3:0] strobe;
    unique case (idx)
      2'd0: strobe = ColStrobe0;
      2'd1: strobe = ColStrobe1;
      2'd2: strobe = ColStrobe2;
      2'd3: strobe = ColStrobe3;
      default: strobe = ColStrobe0;
    endcase
    return strobe;
  endfunction

  // Lowest-index low row wins; returns 3 when no row is low (callers gate on that).
  function automatic logic [1:0] win_row(input logic [3:0] rows);
    logic [1:0] idx;
    if (!rows[0]) begin
      idx = 2'd0;
    end else if (!rows[1]) begin
      idx = 2'd1;
    end else if (!rows[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_row_sync.sv
// Two-flop synchroniser for the asynchronous, active-low keypad rows.
// Resets to all-high so an idle keypad is seen during and after reset.
module keypad_scanner_row_sync
  import keypad_scanner_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] row_s
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  // Two back-to-back stages; only sync_q is used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RowsIdle;
      sync_q <= RowsIdle;
    end else begin
      meta_q <= row_in;
      sync_q <= meta_q;
    end
  end

  assign row_s = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: strobes columns, debounces presses and releases,
// decodes keys and shifts digits into a 16-bit value register.
// Optional macro KEYPAD_CLR_KEY_EN: key 0xF clears value instead of being shifted in.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 400000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        Sclk,
  input  logic        rst_n,
  input  logic [3:0]  row_in,
  input  logic        clear,
  output logic [3:0]  col_out,
  output logic [15:0] value,
  output logic [3:0]  key_code,
  output logic        key_valid
);

  localparam int unsigned DwellW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DebW   = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_DIV - 1);
  localparam logic [DebW-1:0]   DebTarget = DebW'(DEBOUNCE_SCANS);

  logic [3:0]        row_s;
  logic [DwellW-1:0] dwell_q;
  logic              dwell_end;

  scan_state_e       state_q, state_d;
  logic [1:0]        col_idx_q, col_idx_d;
  logic [1:0]        cand_q, cand_d;
  logic [DebW-1:0]   deb_q, deb_d;
  logic [DebW-1:0]   deb_inc;
  logic              accept;
  logic              cand_held;

  logic [3:0]        new_code;
  logic [15:0]       value_shift;
  logic [15:0]       value_q;
  logic [3:0]        key_code_q;
  logic              key_valid_q;

  keypad_scanner_row_sync u_row_sync (
    .clk    (Sclk),
    .rst_n  (rst_n),
    .row_in (row_in),
    .row_s  (row_s)
  );

  // Dwell counter: each column is held for SCAN_DIV cycles.
  always_ff @(posedge Sclk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q <= '0;
    end else if (dwell_end) begin
      dwell_q <= '0;
    end else begin
      dwell_q <= dwell_q + DwellW'(1);
    end
  end

  assign dwell_end = (dwell_q == DwellLast);
  assign deb_inc   = deb_q + DebW'(1);
  assign cand_held = (row_s != RowsIdle) && (win_row(row_s) == cand_q);

  // FSM state register with scan column, candidate row and debounce count.
  always_ff @(posedge Sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StScan;
      col_idx_q <= 2'd0;
      cand_q    <= 2'd0;
      deb_q     <= '0;
    end else begin
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      cand_q    <= cand_d;
      deb_q     <= deb_d;
    end
  end

  // Next-state logic; every decision is taken only at dwell end.
  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    cand_d    = cand_q;
    deb_d     = deb_q;
    accept    = 1'b0;
    if (dwell_end) begin
      unique case (state_q)
        StScan: begin
          if (row_s == RowsIdle) begin
            col_idx_d = col_idx_q + 2'd1;
          end else begin
            cand_d  = win_row(row_s);
            deb_d   = '0;
            state_d = StDebounce;
          end
        end
        StDebounce: begin
          if (cand_held) begin
            if (deb_inc == DebTarget) begin
              accept  = 1'b1;
              deb_d   = '0;
              state_d = StHold;
            end else begin
              deb_d = deb_inc;
            end
          end else begin
            // Press vanished or changed row: drop it and move on.
            state_d   = StScan;
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        StHold: begin
          if (row_s == RowsIdle) begin
            if (deb_inc == DebTarget) begin
              deb_d     = '0;
              state_d   = StScan;
              col_idx_d = col_idx_q + 2'd1;
            end else begin
              deb_d = deb_inc;
            end
          end else begin
            deb_d = '0;
          end
        end
        default: state_d = StScan;
      endcase
    end
  end

  assign new_code = {cand_q, col_idx_q};

  // Next value on an accepted key: shift in, or clear on the clear key if enabled.
  always_comb begin
    value_shift = {value_q[11:0], new_code};
`ifdef KEYPAD_CLR_KEY_EN
    if (new_code == ClrKeyCode) begin
      value_shift = '0;
    end
`else
`endif
  end

  // Registered outputs; clear takes priority over an accept for value only.
  always_ff @(posedge Sclk or negedge rst_n) begin
    if (!rst_n) begin
      value_q     <= '0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
    end else begin
      key_valid_q <= accept;
      if (accept) begin
        key_code_q <= new_code;
      end
      if (clear) begin
        value_q <= '0;
      end else if (accept) begin
        value_q <= value_shift;
      end
    end
  end

  assign col_out   = col_strobe(col_idx_q);
  assign value     = value_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart of the 4-digit multiplexed seven-segment driver.
- Drives the columns of a 4x4 hex keypad one at a time with the same active-low one-hot-zero strobe pattern used for the display anodes, and reads the rows back.
- Debounces each keypress, decodes it to a hex digit, and shifts the digit into a 16-bit value register that feeds the processor operand path and the display.

Parameters:
- SCAN_DIV, 400000, clock cycles each column is held active (dwell).
- DEBOUNCE_SCANS, 4, consecutive dwells a row reading must hold stable to accept a press or a release.

Ports:
- Sclk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- row_in  input  4  keypad rows, active-low, pulled up externally, asynchronous to Sclk.
- clear  input  1  synchronous clear of value.
- col_out  output  4  column strobes, active-low, exactly one bit low.
- value  output  16  entered number; the most recent digit is in [3:0].
- key_code  output  4  code of the last accepted key.
- key_valid  output  1  one-cycle pulse when a key is accepted.

Behaviour:
- Reset (async assert, sync release) sets:
  - col_out=4'b1110, col_idx=0, value=0, key_code=0, key_valid=0.
  - Dwell and debounce counters cleared, synchroniser flops set to 4'hF, state SCAN.
- Synchronisation: row_in passes through a 2-flop synchroniser (row_s). All decisions use row_s only.
- Dwell counter:
  - Counts 0..SCAN_DIV-1, then wraps.
  - "Dwell end" is the cycle where the count equals SCAN_DIV-1.
  - row_s is sampled only at dwell end.
- Column mapping: col_idx 0..3 drives col_out 1110, 1101, 1011, 0111. Column advance 3->0 wraps.
- Row priority: if several rows are low, the lowest row index wins.
- Key decode: key_code = {row_idx[1:0], col_idx[1:0]}, giving values 0x0..0xF.
- States:
  - SCAN: at dwell end, if row_s==4'hF, advance the column. Otherwise latch the candidate row, clear the debounce count, and go to DEBOUNCE. The column does not advance.
  - DEBOUNCE: the column is frozen. At each dwell end:
    - If the candidate row is still the winning low row, increment the count.
    - Otherwise go to SCAN and advance the column.
    - When the count reaches DEBOUNCE_SCANS, accept: pulse key_valid, load key_code, set value <= {value[11:0], key_code}, and go to HOLD.
  - HOLD: the column is frozen. At each dwell end:
    - If row_s==4'hF, increment the release count; any low row resets it to 0.
    - When the count reaches DEBOUNCE_SCANS, go to SCAN and advance the column.
    - No new key is accepted in HOLD, so there is no auto-repeat.
- Accept latency: key_valid rises on the cycle after the DEBOUNCE_SCANS-th stable dwell end, i.e. it is registered. key_code and value update on that same edge.
- Value width: the shift discards value[15:12] (the oldest digit drops out).
- clear:
  - Forces value=0 on the next edge.
  - If clear coincides with an accept, clear wins: value=0, but key_valid and key_code still update.
  - clear does not affect the FSM.
- Glitches: a bounce shorter than one dwell is either not sampled or fails the stability check. A press released during DEBOUNCE produces no output.

Optional Feature:
- KEYPAD_CLR_KEY_EN defined: key 0xF (row 3, col 3) clears value to 0 instead of being shifted in. key_valid still pulses and key_code=0xF.
- Undefined: 0xF is an ordinary digit.

Decomposition:
- Shared package holds:
  - the state enum (SCAN, DEBOUNCE, HOLD);
  - the column strobe constants 4'b1110, 4'b1101, 4'b1011, 4'b0111 (also used by the display driver);
  - the clear-key code 4'hF.
- One natural sub-module, row_sync: the 2-flop, 4-bit synchroniser with reset value 4'hF.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2):
- Idle, row_in=4'hF for 64 cycles -> col_out cycles 1110, 1101, 1011, 0111, 1110, ... each held 4 cycles; key_valid never asserts.
- Press row1 while col_out=1101, held 20 cycles, then released -> exactly one key_valid pulse, key_code=4'h5, value=16'h0005, col_out frozen at 1101 until 2 clean dwells after release.
- Enter keys 1, 2, 3, 4, 5 in sequence -> value=16'h1234 after the fourth key, 16'h2345 after the fifth.
- Bounce: row low for one dwell, high for the next, while in DEBOUNCE -> no key_valid, scan resumes at the next column.
- Rows 0 and 2 both low on col 2 -> key_code=4'h2. clear asserted on the accept cycle -> value=0, key_valid=1.
- rst_n pulsed low mid-DEBOUNCE -> outputs return to reset values immediately. With KEYPAD_CLR_KEY_EN, value=16'h00AB then key 0xF -> value=0, key_code=4'hF.
